// File: rtl/scoreboard_regfile.sv
// Register file with combinational read ports, a single write port with same-cycle
// bypass, and a pending-write scoreboard that flags RAW/WAW hazards to decode.
module scoreboard_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_ready,
    input  logic                     flush,
    output logic [ADDR_W:0]          pend_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [ADDR_W:0]     pend_count_q, pend_count_d;
    logic                wr_commit;
    logic                issue_zero;
    logic                issue_take;

    // An in-flight writeback to the issue target frees it in the same cycle.
    always_comb begin
        wr_commit   = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
        issue_zero  = (ZERO_REG != 0) && (issue_addr == '0);
        issue_ready = issue_zero || !pending_q[issue_addr] || (wr_en && (wr_addr == issue_addr));
        issue_take  = issue_en && issue_ready && !issue_zero;
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;
        logic              is_zero;

        assign addr    = rd_addr[g*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign hit     = wr_en && (wr_addr == addr);
        assign rd_data[g*DATA_W +: DATA_W] = is_zero ? '0 : (hit ? wr_data : regs_q[addr]);
        assign rd_busy[g] = !is_zero && pending_q[addr] && !hit;
    end

    // Statement order encodes pending priority: flush > issue set > writeback clear.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (wr_commit) begin
            regs_d[wr_addr]    = wr_data;
            pending_d[wr_addr] = 1'b0;
        end
        if (issue_take) begin
            pending_d[issue_addr] = 1'b1;
        end
        if (flush) begin
            pending_d = '0;
        end
        pend_count_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_count_d = pend_count_d + (ADDR_W+1)'(pending_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q    <= '0;
            pend_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            pending_q    <= pending_d;
            pend_count_q <= pend_count_d;
        end
    end

    assign pend_count = pend_count_q;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed self-checking bench for scoreboard_regfile: reset, RAW/WAW hazards,
// bypass, register-0 handling, flush and mid-operation reset.
module tb_scoreboard_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int NUM_RD = 2;

    logic                     clk;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     issue_ready;
    logic                     flush;
    logic [ADDR_W:0]          pend_count;

    int checks = 0;
    int passes = 0;

    scoreboard_regfile #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .flush(flush), .pend_count(pend_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0; reset = 1'b0;
        wr_addr = '0; wr_data = '0; issue_addr = '0;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        issue_addr = 6'd9;
        set_rd(6'd5, 6'd63);
        checks++; if (rd_data !== 64'd0) $display("[TB] FAIL reset_rd_data got %h want 0", rd_data); else passes++;
        checks++; if (rd_busy !== 2'b00) $display("[TB] FAIL reset_rd_busy got %b want 00", rd_busy); else passes++;
        checks++; if (pend_count !== 7'd0) $display("[TB] FAIL reset_pend_count got %0d want 0", pend_count); else passes++;
        checks++; if (issue_ready !== 1'b1) $display("[TB] FAIL reset_issue_ready got %b want 1", issue_ready); else passes++;
    endtask

    task automatic test_raw_waw();
        idle();
        issue_en = 1'b1; issue_addr = 6'd3;
        set_rd(6'd3, 6'd3);
        checks++; if (issue_ready !== 1'b1) $display("[TB] FAIL raw_first_issue_ready got %b want 1", issue_ready); else passes++;
        step();
        issue_en = 1'b0;
        #1;
        checks++; if (rd_busy[0] !== 1'b1) $display("[TB] FAIL raw_busy got %b want 1", rd_busy[0]); else passes++;
        checks++; if (pend_count !== 7'd1) $display("[TB] FAIL raw_pend_count got %0d want 1", pend_count); else passes++;
        issue_en = 1'b1;
        #1;
        checks++; if (issue_ready !== 1'b0) $display("[TB] FAIL waw_issue_ready got %b want 0", issue_ready); else passes++;
        step();
        issue_en = 1'b0;
        #1;
        checks++; if (pend_count !== 7'd1) $display("[TB] FAIL waw_pend_hold got %0d want 1", pend_count); else passes++;
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'd16;
        #1;
        checks++; if (rd_data[31:0] !== 32'd16) $display("[TB] FAIL bypass_data got %0d want 16", rd_data[31:0]); else passes++;
        checks++; if (rd_busy[0] !== 1'b0) $display("[TB] FAIL bypass_busy got %b want 0", rd_busy[0]); else passes++;
        checks++; if (issue_ready !== 1'b1) $display("[TB] FAIL bypass_issue_ready got %b want 1", issue_ready); else passes++;
        step();
        wr_en = 1'b0;
        #1;
        checks++; if (pend_count !== 7'd0) $display("[TB] FAIL wb_pend_clear got %0d want 0", pend_count); else passes++;
        checks++; if (rd_data[63:32] !== 32'd16) $display("[TB] FAIL wb_stored got %0d want 16", rd_data[63:32]); else passes++;
    endtask

    task automatic test_same_cycle_wb_issue();
        idle();
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'hFFFFF800;
        issue_en = 1'b1; issue_addr = 6'd7;
        set_rd(6'd7, 6'd7);
        checks++; if (issue_ready !== 1'b1) $display("[TB] FAIL same_issue_ready got %b want 1", issue_ready); else passes++;
        step();
        idle();
        #1;
        checks++; if (rd_data !== {2{32'hFFFFF800}}) $display("[TB] FAIL same_data got %h want fffff800fffff800", rd_data); else passes++;
        checks++; if (rd_busy !== 2'b11) $display("[TB] FAIL same_busy got %b want 11", rd_busy); else passes++;
        checks++; if (pend_count !== 7'd1) $display("[TB] FAIL same_pend got %0d want 1", pend_count); else passes++;
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'hFFFFF800;
        step();
        idle();
        #1;
        checks++; if (pend_count !== 7'd0) $display("[TB] FAIL same_cleanup_pend got %0d want 0", pend_count); else passes++;
    endtask

    task automatic test_zero_reg();
        idle();
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = 32'd31;
        issue_en = 1'b1; issue_addr = 6'd0;
        set_rd(6'd0, 6'd0);
        checks++; if (rd_data[31:0] !== 32'd0) $display("[TB] FAIL zero_bypass_data got %0d want 0", rd_data[31:0]); else passes++;
        checks++; if (issue_ready !== 1'b1) $display("[TB] FAIL zero_issue_ready got %b want 1", issue_ready); else passes++;
        step();
        idle();
        #1;
        checks++; if (rd_data !== 64'd0) $display("[TB] FAIL zero_data got %h want 0", rd_data); else passes++;
        checks++; if (rd_busy !== 2'b00) $display("[TB] FAIL zero_busy got %b want 00", rd_busy); else passes++;
        checks++; if (pend_count !== 7'd0) $display("[TB] FAIL zero_pend got %0d want 0", pend_count); else passes++;
    endtask

    task automatic test_flush();
        idle();
        issue_en = 1'b1;
        issue_addr = 6'd2;  step();
        issue_addr = 6'd8;  step();
        issue_addr = 6'd11; step();
        idle();
        #1;
        checks++; if (pend_count !== 7'd3) $display("[TB] FAIL flush_pre_pend got %0d want 3", pend_count); else passes++;
        flush = 1'b1;
        issue_en = 1'b1; issue_addr = 6'd12;
        wr_en = 1'b1; wr_addr = 6'd8; wr_data = 32'd9;
        step();
        idle();
        set_rd(6'd8, 6'd12);
        checks++; if (pend_count !== 7'd0) $display("[TB] FAIL flush_pend got %0d want 0", pend_count); else passes++;
        checks++; if (rd_data[31:0] !== 32'd9) $display("[TB] FAIL flush_wr_commit got %0d want 9", rd_data[31:0]); else passes++;
        checks++; if (rd_busy !== 2'b00) $display("[TB] FAIL flush_busy_8_12 got %b want 00", rd_busy); else passes++;
        set_rd(6'd2, 6'd11);
        checks++; if (rd_busy !== 2'b00) $display("[TB] FAIL flush_busy_2_11 got %b want 00", rd_busy); else passes++;
    endtask

    task automatic test_back_to_back();
        idle();
        wr_en = 1'b1;
        wr_addr = 6'd10; wr_data = 32'hA5A5_0001; step();
        wr_addr = 6'd11; wr_data = 32'h5A5A_0002;
        set_rd(6'd10, 6'd11);
        checks++; if (rd_data !== {32'h5A5A_0002, 32'hA5A5_0001}) $display("[TB] FAIL b2b_bypass got %h want 5a5a0002a5a50001", rd_data); else passes++;
        step();
        idle();
        #1;
        checks++; if (rd_data !== {32'h5A5A_0002, 32'hA5A5_0001}) $display("[TB] FAIL b2b_stored got %h want 5a5a0002a5a50001", rd_data); else passes++;
    endtask

    task automatic test_reset_mid();
        idle();
        wr_en = 1'b1; wr_addr = 6'd4; wr_data = 32'h0000ABCD;
        step();
        idle();
        issue_en = 1'b1;
        issue_addr = 6'd4; step();
        issue_addr = 6'd5; step();
        idle();
        set_rd(6'd4, 6'd5);
        checks++; if (pend_count !== 7'd2) $display("[TB] FAIL mid_pre_pend got %0d want 2", pend_count); else passes++;
        checks++; if (rd_data[31:0] !== 32'h0000ABCD) $display("[TB] FAIL mid_pre_data got %h want 0000abcd", rd_data[31:0]); else passes++;
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 6'd4; wr_data = 32'h1234;
        issue_en = 1'b1; issue_addr = 6'd6;
        step();
        idle();
        set_rd(6'd4, 6'd5);
        checks++; if (rd_data[31:0] !== 32'd0) $display("[TB] FAIL mid_reg4 got %h want 0", rd_data[31:0]); else passes++;
        checks++; if (pend_count !== 7'd0) $display("[TB] FAIL mid_pend got %0d want 0", pend_count); else passes++;
        checks++; if (rd_busy !== 2'b00) $display("[TB] FAIL mid_busy_4_5 got %b want 00", rd_busy); else passes++;
        set_rd(6'd6, 6'd6);
        checks++; if (rd_busy !== 2'b00) $display("[TB] FAIL mid_busy_6 got %b want 00", rd_busy); else passes++;
    endtask

    initial begin
        idle();
        rd_addr = '0;
        test_reset();
        test_raw_waw();
        test_same_cycle_wb_issue();
        test_zero_reg();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/scoreboard_regfile.md
Name: scoreboard_regfile

Overview:
Parametrised successor to the pipeline's register file. It provides NUM_RD combinational read ports and one synchronous write port, with write-to-read bypass. A per-register pending-write scoreboard lets the ID stage detect RAW and WAW hazards without extra NOP padding. It sits in ID: reads and issue come from decode, and writes and scoreboard clears come from the EX/WB buffer.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 6: register address width; the file holds 2**ADDR_W registers.
- NUM_RD, 2: number of independent read ports.
- ZERO_REG, 1: when 1, register 0 always reads 0, ignores writes and is never pending.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- rd_addr, input, NUM_RD*ADDR_W: packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data, output, NUM_RD*DATA_W: packed read data, combinational.
- rd_busy, output, NUM_RD: port i's register has an outstanding write.
- wr_en, input, 1: writeback strobe.
- wr_addr, input, ADDR_W: writeback destination.
- wr_data, input, DATA_W: writeback value.
- issue_en, input, 1: decode issues an instruction that will write issue_addr.
- issue_addr, input, ADDR_W: destination register of the issuing instruction.
- issue_ready, output, 1: issue is accepted this cycle (no WAW conflict).
- flush, input, 1: squash all outstanding pending bits (branch or jump taken).
- pend_count, output, ADDR_W+1: registered count of set pending bits.

Behaviour:
- Reset (synchronous, takes effect at the clk edge while reset=1):
  - All registers become 0, all pending bits 0, pend_count 0.
  - Reset overrides write, issue and flush in the same cycle.
  - Reset mid-operation discards everything.
- Outputs after reset: rd_data = 0 for any address, rd_busy = 0, issue_ready = 1.
- Read path, combinational, zero latency:
  - If wr_en=1 and wr_addr==rd_addr[i], rd_data[i] = wr_data (bypass).
  - Otherwise rd_data[i] = regs[rd_addr[i]].
  - If ZERO_REG=1 and rd_addr[i]==0, rd_data[i] = 0 regardless of bypass.
- rd_busy[i] = pending[rd_addr[i]] AND NOT (wr_en AND wr_addr==rd_addr[i]). The writeback in flight resolves the hazard in the same cycle. rd_busy[i] = 0 for address 0 when ZERO_REG=1.
- Write: at the clk edge with wr_en=1, regs[wr_addr] <= wr_data and pending[wr_addr] <= 0. A write to a non-pending register is legal and commits with no scoreboard change. A write to register 0 is dropped when ZERO_REG=1.
- issue_ready = NOT pending[issue_addr] OR (wr_en AND wr_addr==issue_addr). It is 1 for address 0 when ZERO_REG=1. It is valid regardless of issue_en.
- Issue: at the clk edge with issue_en=1 and issue_ready=1, pending[issue_addr] <= 1.
  - issue_en with issue_ready=0 changes no state; decode must hold and retry.
  - Issue to register 0 with ZERO_REG=1 is accepted and leaves no pending bit.
- Same-cycle writeback and issue to the same address: the data is written and the pending bit ends at 1, because the new writer owns the register.
- Flush: at the clk edge, all pending bits <= 0. Flush beats a same-cycle issue (the issue is discarded), but a same-cycle wr_en write still commits its data.
- Priority per pending bit: reset > flush > issue set > writeback clear.
- pend_count updates on the same edge as the pending bits and always equals popcount(pending). It is never updated combinationally.
- Multiple read ports may address the same register; all return identical data and busy.

Test Plan:
- Reset, then read ports 0/1 at addresses 5/63 -> rd_data=0/0, rd_busy=0, pend_count=0, issue_ready=1.
- Issue addr 3; next cycle read addr 3 -> rd_busy[0]=1, pend_count=1. A further issue to addr 3 -> issue_ready=0 and pend_count stays 1. Write 3 <= 32'd16 -> in that cycle rd_data=16, rd_busy=0. After the edge pend_count=0.
- Same cycle: wr_en to addr 7 with 32'hFFFFF800, issue to addr 7 -> issue_ready=1. After the edge regs[7]=32'hFFFFF800, rd_busy for 7 = 1, pend_count=1.
- Write addr 0 <= 32'd31 and issue addr 0 with ZERO_REG=1 -> rd_data at addr 0 = 0, rd_busy=0, pend_count unchanged.
- Issue addrs 2, 8, 11 on consecutive cycles (pend_count=3). Then flush together with issue 12 and write 8 <= 9 -> pend_count=0, regs[8]=9, rd_busy[12]=0.
- Issue 4 and 5, then assert reset for one cycle together with wr_en to addr 4 -> afterwards regs[4]=0, pend_count=0, all rd_busy=0.
